backtrack_unit: RTL and testbench

//  Conflict-recovery engine of the DPLL solver; the read/consume end of the trace stack,

---
 rtl/backtrack_unit.sv | 133 +++++++++++++
 tb/tb_backtrack_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/backtrack_unit.sv
// rtl/backtrack_unit.sv - conflict backtrack engine: flushes implications, unwinds trace to last decision, flips it
module backtrack_unit #(
    parameter int VAR_BITS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                unsat_out,
    output logic [VAR_BITS-1:0] flip_var,
    output logic                flip_val,
    output logic                clear_imply,
    input  logic                empty_trace,
    input  logic [VAR_BITS-1:0] var_out_trace,
    input  logic                val_out_trace,
    input  logic                type_out_trace,
    output logic                pop_trace,
    output logic                push_trace,
    output logic [VAR_BITS-1:0] var_in_trace,
    output logic                val_in_trace,
    output logic                type_in_trace,
    output logic                write_vs,
    output logic [VAR_BITS-1:0] var_in_vs,
    output logic                val_in_vs,
    output logic                unassign_in_vs
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_POP,
        S_FLIP,
        S_DONE,
        S_UNSAT
    } state_t;

    state_t              state_q, state_d;
    logic [VAR_BITS-1:0] flip_var_q, flip_var_d;
    logic                flip_val_q, flip_val_d;

    // Next-state logic; the decision found while unwinding is captured here with its value inverted
    always_comb begin
        state_d    = state_q;
        flip_var_d = flip_var_q;
        flip_val_d = flip_val_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_POP;
            end
            S_POP: begin
                if (empty_trace) begin
                    state_d = S_UNSAT;
                end else if (!type_out_trace) begin
                    flip_var_d = var_out_trace;
                    flip_val_d = ~val_out_trace;
                    state_d    = S_FLIP;
                end
            end
            S_FLIP:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_UNSAT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and flipped-decision registers; reset aborts any unwind in progress
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            flip_var_q <= '0;
            flip_val_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            flip_var_q <= flip_var_d;
            flip_val_q <= flip_val_d;
        end
    end

    // Output decode: strobes follow the state, except in POP where they follow the trace top
    always_comb begin
        clear_imply    = 1'b0;
        pop_trace      = 1'b0;
        push_trace     = 1'b0;
        var_in_trace   = '0;
        val_in_trace   = 1'b0;
        type_in_trace  = 1'b0;
        write_vs       = 1'b0;
        var_in_vs      = '0;
        val_in_vs      = 1'b0;
        unassign_in_vs = 1'b0;
        done           = 1'b0;
        unsat_out      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                clear_imply = 1'b1;
            end
            S_POP: begin
                if (!empty_trace) begin
                    pop_trace = 1'b1;
                    if (type_out_trace) begin
                        write_vs       = 1'b1;
                        var_in_vs      = var_out_trace;
                        unassign_in_vs = 1'b1;
                    end
                end
            end
            S_FLIP: begin
                // The decision pop just freed a slot, so this push never overflows
                push_trace    = 1'b1;
                var_in_trace  = flip_var_q;
                val_in_trace  = flip_val_q;
                type_in_trace = 1'b1;
                write_vs      = 1'b1;
                var_in_vs     = flip_var_q;
                val_in_vs     = flip_val_q;
            end
            S_DONE:  done      = 1'b1;
            S_UNSAT: unsat_out = 1'b1;
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign flip_var = flip_var_q;
    assign flip_val = flip_val_q;

endmodule

// File: tb/tb_backtrack_unit.sv
// tb/tb_backtrack_unit.sv - directed self-checking bench for backtrack_unit with a trace stack model
module tb_backtrack_unit;

    localparam int VB = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, unsat_out, flip_val, clear_imply;
    logic [VB-1:0] flip_var;
    logic          empty_trace;
    logic [VB-1:0] var_out_trace;
    logic          val_out_trace, type_out_trace;
    logic          pop_trace, push_trace;
    logic [VB-1:0] var_in_trace;
    logic          val_in_trace, type_in_trace;
    logic          write_vs;
    logic [VB-1:0] var_in_vs;
    logic          val_in_vs, unassign_in_vs;

    int checks = 0;
    int failures = 0;

    // trace stack model
    logic [VB-1:0] stk_var [0:15];
    logic          stk_val [0:15];
    logic          stk_typ [0:15];
    int            depth = 0;
    int            top_idx;
    logic          tb_push = 1'b0;
    logic          tb_clr = 1'b0;
    logic [VB-1:0] tb_var = '0;
    logic          tb_val = 1'b0;
    logic          tb_typ = 1'b0;

    always #5 clock = ~clock;

    backtrack_unit #(.VAR_BITS(VB)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .unsat_out(unsat_out), .flip_var(flip_var), .flip_val(flip_val),
        .clear_imply(clear_imply), .empty_trace(empty_trace),
        .var_out_trace(var_out_trace), .val_out_trace(val_out_trace),
        .type_out_trace(type_out_trace), .pop_trace(pop_trace), .push_trace(push_trace),
        .var_in_trace(var_in_trace), .val_in_trace(val_in_trace),
        .type_in_trace(type_in_trace), .write_vs(write_vs), .var_in_vs(var_in_vs),
        .val_in_vs(val_in_vs), .unassign_in_vs(unassign_in_vs)
    );

    assign top_idx        = (depth == 0) ? 0 : depth - 1;
    assign empty_trace    = (depth == 0);
    assign var_out_trace  = stk_var[top_idx];
    assign val_out_trace  = stk_val[top_idx];
    assign type_out_trace = stk_typ[top_idx];

    always @(posedge clock) begin
        if (tb_clr) begin
            depth <= 0;
        end else if (tb_push) begin
            stk_var[depth] <= tb_var;
            stk_val[depth] <= tb_val;
            stk_typ[depth] <= tb_typ;
            depth <= depth + 1;
        end else begin
            if (pop_trace && depth > 0) depth <= depth - 1;
            if (push_trace) begin
                stk_var[depth] <= var_in_trace;
                stk_val[depth] <= val_in_trace;
                stk_typ[depth] <= type_in_trace;
                depth <= depth + 1;
            end
        end
    end

    // {clear_imply, pop, push, write_vs, done, unsat_out, busy}
    function automatic logic [6:0] obs();
        return {clear_imply, pop_trace, push_trace, write_vs, done, unsat_out, busy};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic tr_clear();
        tb_clr = 1'b1;
        step();
        tb_clr = 1'b0;
    endtask

    task automatic tr_push(input logic [VB-1:0] v, input logic val, input logic typ);
        tb_var = v; tb_val = val; tb_typ = typ; tb_push = 1'b1;
        step();
        tb_push = 1'b0;
    endtask

    task automatic load_test1();
        tr_clear();
        tr_push(8'd3, 1'b1, 1'b0);
        tr_push(8'd5, 1'b0, 1'b1);
        tr_push(8'd7, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (obs() !== 7'b0) begin
            failures++; $display("FAIL reset_obs got %b exp %b", obs(), 7'b0);
        end
        checks++;
        if ({flip_var, flip_val, var_in_vs, var_in_trace} !== '0) begin
            failures++; $display("FAIL reset_data got %h/%b exp 0", flip_var, flip_val);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_conflict_flip();
        logic [6:0] e [1:7];
        e[1] = 7'b1000001; e[2] = 7'b0101001; e[3] = 7'b0101001; e[4] = 7'b0100001;
        e[5] = 7'b0011001; e[6] = 7'b0000101; e[7] = 7'b0000000;
        load_test1();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            checks++;
            if (obs() !== e[c]) begin
                failures++; $display("FAIL t1_obs c%0d got %b exp %b", c, obs(), e[c]);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({var_in_vs, unassign_in_vs} !== {(c == 2) ? 8'd7 : 8'd5, 1'b1}) begin
                    failures++; $display("FAIL t1_unassign c%0d got %0d/%b", c, var_in_vs, unassign_in_vs);
                end
            end
            if (c == 5) begin
                checks++;
                if ({var_in_trace, val_in_trace, type_in_trace, var_in_vs, val_in_vs, unassign_in_vs}
                    !== {8'd3, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0}) begin
                    failures++; $display("FAIL t1_push got %0d/%b/%b vs %0d/%b/%b exp 3/0/1 3/0/0",
                        var_in_trace, val_in_trace, type_in_trace, var_in_vs, val_in_vs, unassign_in_vs);
                end
            end
            if (c == 6 || c == 7) begin
                checks++;
                if ({flip_var, flip_val} !== {8'd3, 1'b0}) begin
                    failures++; $display("FAIL t1_flip c%0d got %0d/%b exp 3/0", c, flip_var, flip_val);
                end
            end
            step();
        end
        checks++;
        if (depth !== 1 || stk_var[0] !== 8'd3 || stk_val[0] !== 1'b0 || stk_typ[0] !== 1'b1) begin
            failures++; $display("FAIL t1_trace got depth %0d top %0d/%b/%b exp 1 3/0/1",
                depth, stk_var[0], stk_val[0], stk_typ[0]);
        end
    endtask

    task automatic test_single_decision();
        logic [6:0] e [1:5];
        e[1] = 7'b1000001; e[2] = 7'b0100001; e[3] = 7'b0011001; e[4] = 7'b0000101; e[5] = 7'b0;
        tr_clear();
        tr_push(8'd2, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (obs() !== e[c]) begin
                failures++; $display("FAIL t2_obs c%0d got %b exp %b", c, obs(), e[c]);
            end
            if (c == 3) begin
                checks++;
                if ({var_in_trace, val_in_trace, var_in_vs, val_in_vs} !== {8'd2, 1'b1, 8'd2, 1'b1}) begin
                    failures++; $display("FAIL t2_push got %0d/%b %0d/%b exp 2/1 2/1",
                        var_in_trace, val_in_trace, var_in_vs, val_in_vs);
                end
            end
            if (c == 4) begin
                checks++;
                if ({flip_var, flip_val} !== {8'd2, 1'b1}) begin
                    failures++; $display("FAIL t2_flip got %0d/%b exp 2/1", flip_var, flip_val);
                end
            end
            step();
        end
        checks++;
        if (depth !== 1) begin
            failures++; $display("FAIL t2_depth got %0d exp 1", depth);
        end
    endtask

    task automatic test_unsat_forced();
        logic [6:0] e [1:6];
        e[1] = 7'b1000001; e[2] = 7'b0101001; e[3] = 7'b0101001; e[4] = 7'b0000001;
        e[5] = 7'b0000011; e[6] = 7'b0;
        tr_clear();
        tr_push(8'd1, 1'b1, 1'b1);
        tr_push(8'd4, 1'b0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (obs() !== e[c]) begin
                failures++; $display("FAIL t3_obs c%0d got %b exp %b", c, obs(), e[c]);
            end
            if (c == 2 || c == 3) begin
                checks++;
                if ({var_in_vs, val_in_vs, unassign_in_vs} !== {(c == 2) ? 8'd4 : 8'd1, 1'b0, 1'b1}) begin
                    failures++; $display("FAIL t3_unassign c%0d got %0d/%b/%b", c, var_in_vs, val_in_vs, unassign_in_vs);
                end
            end
            step();
        end
        checks++;
        if (depth !== 0) begin
            failures++; $display("FAIL t3_depth got %0d exp 0", depth);
        end
    endtask

    task automatic test_empty_trace();
        logic [6:0] e [1:4];
        e[1] = 7'b1000001; e[2] = 7'b0000001; e[3] = 7'b0000011; e[4] = 7'b0;
        tr_clear();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if (obs() !== e[c]) begin
                failures++; $display("FAIL t4_obs c%0d got %b exp %b", c, obs(), e[c]);
            end
            step();
        end
    endtask

    task automatic test_start_ignored();
        logic [6:0] e [1:8];
        e[1] = 7'b1000001; e[2] = 7'b0101001; e[3] = 7'b0101001; e[4] = 7'b0100001;
        e[5] = 7'b0011001; e[6] = 7'b0000101; e[7] = 7'b0; e[8] = 7'b0;
        load_test1();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if (obs() !== e[c]) begin
                failures++; $display("FAIL t5_obs c%0d got %b exp %b", c, obs(), e[c]);
            end
            start = (c == 3 || c == 6);
            step();
        end
        start = 1'b0;
        checks++;
        if (depth !== 1) begin
            failures++; $display("FAIL t5_depth got %0d exp 1", depth);
        end
    endtask

    task automatic test_reset_mid_pop();
        logic [6:0] e [1:6];
        load_test1();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (obs() !== 7'b1000001) begin
            failures++; $display("FAIL t6_c1 got %b exp %b", obs(), 7'b1000001);
        end
        step();
        checks++;
        if (obs() !== 7'b0101001 || var_in_vs !== 8'd7) begin
            failures++; $display("FAIL t6_c2 got %b/%0d exp 0101001/7", obs(), var_in_vs);
        end
        step();
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 7'b0 || var_in_vs !== 8'd0 || flip_var !== 8'd0 || flip_val !== 1'b0) begin
            failures++; $display("FAIL t6_async got %b/%0d/%0d exp 0", obs(), var_in_vs, flip_var);
        end
        step();
        reset_n = 1'b1;
        checks++;
        if (depth !== 2) begin
            failures++; $display("FAIL t6_depth got %0d exp 2", depth);
        end
        e[1] = 7'b1000001; e[2] = 7'b0101001; e[3] = 7'b0100001; e[4] = 7'b0011001;
        e[5] = 7'b0000101; e[6] = 7'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            checks++;
            if (obs() !== e[c]) begin
                failures++; $display("FAIL t6_obs c%0d got %b exp %b", c, obs(), e[c]);
            end
            if (c == 2) begin
                checks++;
                if (var_in_vs !== 8'd5) begin
                    failures++; $display("FAIL t6_unassign got %0d exp 5", var_in_vs);
                end
            end
            if (c == 5) begin
                checks++;
                if ({flip_var, flip_val} !== {8'd3, 1'b0}) begin
                    failures++; $display("FAIL t6_flip got %0d/%b exp 3/0", flip_var, flip_val);
                end
            end
            step();
        end
        checks++;
        if (depth !== 1) begin
            failures++; $display("FAIL t6_final_depth got %0d exp 1", depth);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_conflict_flip();
        test_single_decision();
        test_unsat_forced();
        test_empty_trace();
        test_start_ignored();
        test_reset_mid_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
